// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter for RAM port A with tagged read returns
module ram_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    // One stage per edge between accept and the edge that registers q_a.
    localparam int STAGES = RD_LAT + 1;

    // Round-robin pointer: 1 means requester 1 won the last accept.
    logic last_q, last_d;

    logic gnt0_c, gnt1_c;
    logic acc_c;
    logic acc_we_c;
    logic acc_id_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [DATA_W-1:0] acc_data_c;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;

    // Read tag pipeline: stage 0 is loaded on the accept edge.
    logic [STAGES-1:0] tag_vld_q, tag_vld_d;
    logic [STAGES-1:0] tag_id_q,  tag_id_d;

    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;

    // Grant decision: single requester wins outright, ties go by pointer or fixed priority.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (req0 && req1) begin
            if ((FIXED_PRIO != 0) || last_q) begin
                gnt0_c = 1'b1;
            end else begin
                gnt1_c = 1'b1;
            end
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

    // Nothing is granted while reset is held, so no transfer can be claimed then.
    assign gnt0 = gnt0_c & aclr_n;
    assign gnt1 = gnt1_c & aclr_n;

    // Mux the winning requester's command onto the accept path.
    always_comb begin
        acc_c      = gnt0_c | gnt1_c;
        acc_id_c   = gnt1_c;
        acc_we_c   = we0;
        acc_addr_c = addr0;
        acc_data_c = wdata0;
        if (gnt1_c) begin
            acc_we_c   = we1;
            acc_addr_c = addr1;
            acc_data_c = wdata1;
        end
    end

    // Next-state for the RAM command registers and the arbitration pointer.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        last_d     = last_q;
        if (acc_c) begin
            ram_addr_d = acc_addr_c;
            ram_data_d = acc_data_c;
            ram_wren_d = acc_we_c;
            last_d     = acc_id_c;
        end
    end

    // Shift the read tags; only reads enter the pipeline, writes have no response.
    always_comb begin
        tag_vld_d = {tag_vld_q[STAGES-2:0], acc_c & ~acc_we_c};
        tag_id_d  = {tag_id_q[STAGES-2:0],  acc_id_c};
    end

    // Return path: the last tag stage says q_a is valid now and who owns it.
    always_comb begin
        rvalid0_d = tag_vld_q[RD_LAT] & ~tag_id_q[RD_LAT];
        rvalid1_d = tag_vld_q[RD_LAT] &  tag_id_q[RD_LAT];
        rdata_d   = rdata_q;
        if (tag_vld_q[RD_LAT]) begin
            rdata_d = ram_q;
        end
    end

    // State registers; reset drops in-flight reads and any write not yet committed.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            last_q     <= 1'b1;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            last_q     <= last_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_wren = ram_wren_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata    = rdata_q;
    assign busy     = |tag_vld_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter in two configurations
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done_arr [2];

    typedef struct {
        int         due;
        bit         id;
        logic [7:0] data;
    } rd_t;

    typedef struct {
        int          due;
        logic        wren;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int LAT = (gi == 0) ? 1 : 2;
        localparam int FP  = (gi == 0) ? 0 : 1;

        logic        aclr_n;
        logic        req0, we0, req1, we1;
        logic [15:0] addr0, addr1;
        logic [7:0]  wdata0, wdata1;
        logic        gnt0, gnt1, rvalid0, rvalid1, ram_wren, busy;
        logic [7:0]  rdata, ram_data, ram_q;
        logic [15:0] ram_addr;

        bit [7:0] ram_m  [0:65535];
        bit [7:0] shadow [0:65535];
        bit [7:0] qp     [0:3];

        int          cyc = 0;
        bit          mon_en = 1'b0;
        rd_t         rq [$];
        bus_t        bq [$];
        int          last_w = 1;
        logic [15:0] hold_a = 16'h0;
        logic [7:0]  hold_d = 8'h0;

        ram_port_arbiter #(
            .ADDR_W(16), .DATA_W(8), .RD_LAT(LAT), .FIXED_PRIO(FP)
        ) u_dut (
            .clk(clk), .aclr_n(aclr_n),
            .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
            .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
            .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
            .ram_q(ram_q), .busy(busy)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // RAM port A: registered address, write commits at capture, q valid LAT-1 edges later
        always @(posedge clk) begin
            if (ram_wren) ram_m[ram_addr] <= ram_data;
            qp[0] <= ram_wren ? ram_data : ram_m[ram_addr];
            for (int k = 1; k < 4; k++) qp[k] <= qp[k-1];
        end
        assign ram_q = qp[LAT-1];

        task automatic drive(input bit r0, input bit w0, input logic [15:0] a0, input logic [7:0] d0,
                             input bit r1, input bit w1, input logic [15:0] a1, input logic [7:0] d1,
                             output bit g0, output bit g1);
            int          win;
            bit          w;
            logic [15:0] a;
            logic [7:0]  d;
            @(negedge clk);
            req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
            req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
            #1;
            if (r0 && r1)  win = (FP != 0) ? 0 : 1 - last_w;
            else if (r0)   win = 0;
            else if (r1)   win = 1;
            else           win = -1;
            g0 = (win == 0);
            g1 = (win == 1);
            check($sformatf("c%0d gnt0", gi), {31'b0, gnt0}, {31'b0, g0});
            check($sformatf("c%0d gnt1", gi), {31'b0, gnt1}, {31'b0, g1});
            if (win >= 0) begin
                w = (win == 1) ? w1 : w0;
                a = (win == 1) ? a1 : a0;
                d = (win == 1) ? d1 : d0;
                bq.push_back('{due: cyc + 1, wren: w, addr: a, data: d});
                if (!w) rq.push_back('{due: cyc + 1 + LAT + 1, id: (win == 1), data: shadow[a]});
                else    shadow[a] = d;
                hold_a = a;
                hold_d = d;
                last_w = win;
            end else begin
                bq.push_back('{due: cyc + 1, wren: 1'b0, addr: hold_a, data: hold_d});
            end
        endtask

        task automatic idle(input int n);
            bit g0, g1;
            for (int i = 0; i < n; i++)
                drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
        endtask

        // Monitor: compares registered outputs against the expectation queues each cycle
        initial begin : monitor
            bus_t b;
            rd_t  r;
            bit   e0, e1, eb;
            forever begin
                @(posedge clk);
                #2;
                if (mon_en && aclr_n) begin
                    if (bq.size() > 0 && bq[0].due == cyc) begin
                        b = bq.pop_front();
                        check($sformatf("c%0d ram_wren", gi), {31'b0, ram_wren}, {31'b0, b.wren});
                        check($sformatf("c%0d ram_addr", gi), {16'b0, ram_addr}, {16'b0, b.addr});
                        check($sformatf("c%0d ram_data", gi), {24'b0, ram_data}, {24'b0, b.data});
                    end
                    e0 = (rq.size() > 0) && (rq[0].due == cyc) && !rq[0].id;
                    e1 = (rq.size() > 0) && (rq[0].due == cyc) &&  rq[0].id;
                    check($sformatf("c%0d rvalid0", gi), {31'b0, rvalid0}, {31'b0, e0});
                    check($sformatf("c%0d rvalid1", gi), {31'b0, rvalid1}, {31'b0, e1});
                    if (rq.size() > 0 && rq[0].due == cyc) begin
                        r = rq.pop_front();
                        check($sformatf("c%0d rdata", gi), {24'b0, rdata}, {24'b0, r.data});
                    end
                    eb = 1'b0;
                    foreach (rq[j]) if (rq[j].due > cyc) eb = 1'b1;
                    check($sformatf("c%0d busy", gi), {31'b0, busy}, {31'b0, eb});
                end
            end
        end

        // Driver: reset, directed scenarios, then constrained-random traffic
        initial begin : driver
            bit          g0, g1;
            bit          pr0, pw0, pr1, pw1;
            bit          ng0, ng1;
            logic [15:0] pa0, pa1;
            logic [7:0]  pd0, pd1;
            aclr_n = 1'b0;
            req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 8'h0;
            req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 8'h0;
            repeat (3) @(negedge clk);
            req0 = 1'b1; req1 = 1'b1;
            #1;
            check($sformatf("c%0d rst gnt0", gi), {31'b0, gnt0}, 32'h0);
            check($sformatf("c%0d rst gnt1", gi), {31'b0, gnt1}, 32'h0);
            check($sformatf("c%0d rst rvalid0", gi), {31'b0, rvalid0}, 32'h0);
            check($sformatf("c%0d rst rvalid1", gi), {31'b0, rvalid1}, 32'h0);
            check($sformatf("c%0d rst busy", gi), {31'b0, busy}, 32'h0);
            check($sformatf("c%0d rst ram_wren", gi), {31'b0, ram_wren}, 32'h0);
            check($sformatf("c%0d rst ram_addr", gi), {16'b0, ram_addr}, 32'h0);
            check($sformatf("c%0d rst ram_data", gi), {24'b0, ram_data}, 32'h0);
            check($sformatf("c%0d rst rdata", gi), {24'b0, rdata}, 32'h0);
            req0 = 1'b0; req1 = 1'b0;
            #1 aclr_n = 1'b1;
            mon_en = 1'b1;

            // write then read back by the other requester
            drive(1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
            idle(1);
            drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0010, 8'h00, g0, g1);
            drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0010, 8'h00, g0, g1);
            drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h00, g0, g1);
            idle(LAT + 2);

            // contention: both read for 4 cycles, then requester 1 alone
            repeat (4) drive(1'b1, 1'b0, 16'h0010, 8'h11, 1'b1, 1'b0, 16'h0011, 8'h22, g0, g1);
            drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0011, 8'h22, g0, g1);
            idle(LAT + 2);

            // read immediately after write to the same address
            drive(1'b1, 1'b1, 16'h0020, 8'h5A, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
            drive(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
            idle(LAT + 2);

            // reset while a read is in flight
            drive(1'b1, 1'b0, 16'h0003, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, g0, g1);
            @(negedge clk);
            req0 = 1'b0;
            #1;
            check($sformatf("c%0d pre-rst busy", gi), {31'b0, busy}, 32'h1);
            #1 aclr_n = 1'b0;
            #1;
            check($sformatf("c%0d mid-rst rvalid0", gi), {31'b0, rvalid0}, 32'h0);
            check($sformatf("c%0d mid-rst rvalid1", gi), {31'b0, rvalid1}, 32'h0);
            check($sformatf("c%0d mid-rst busy", gi), {31'b0, busy}, 32'h0);
            rq.delete();
            bq.delete();
            last_w = 1;
            hold_a = 16'h0;
            hold_d = 8'h0;
            @(negedge clk);
            #2 aclr_n = 1'b1;
            idle(LAT + 3);

            // random traffic; a losing requester holds its command until accepted
            pr0 = 1'b0; pr1 = 1'b0; ng0 = 1'b1; ng1 = 1'b1;
            pw0 = 1'b0; pw1 = 1'b0; pa0 = 16'h0; pa1 = 16'h0; pd0 = 8'h0; pd1 = 8'h0;
            for (int i = 0; i < 400; i++) begin
                if (!pr0 || ng0) begin
                    pr0 = ($urandom_range(0, 2) != 0);
                    pw0 = 1'($urandom);
                    pa0 = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                    pd0 = 8'($urandom);
                end
                if (!pr1 || ng1) begin
                    pr1 = ($urandom_range(0, 2) != 0);
                    pw1 = 1'($urandom);
                    pa1 = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                    pd1 = 8'($urandom);
                end
                drive(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1, ng0, ng1);
            end
            idle(LAT + 3);
            check($sformatf("c%0d reads outstanding", gi), rq.size(), 32'h0);
            done_arr[gi] = 1'b1;
        end
    end

    initial begin : finisher
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 20000 && !all_done; t++) begin
            @(posedge clk);
            all_done = done_arr[0] && done_arr[1];
        end
        check("run completed", {31'b0, all_done}, 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
